e203_ifu_flushrsp: RTL and testbench
====================================

E203_IFU_FLUSHRSP -- requirements
Module: e203_ifu_flushrsp

Interface
REQ-001 SHALL have parameter OSTD_MAX, default 2, the maximum number of outstanding IFU fetch requests (1..3).
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port pipe_flush_req, input, 1, flush request from the EXU commit stage.
REQ-005 SHALL have port pipe_flush_ack, output, 1, flush accept.
REQ-006 SHALL have port pipe_flush_add_op1, input, E203_PC_SIZE, flush target addend 1.
REQ-007 SHALL have port pipe_flush_add_op2, input, E203_PC_SIZE, flush target addend 2.
REQ-008 SHALL have port ifu_req_hsked, input, 1, a fetch bus request handshake occurred this cycle.
REQ-009 SHALL have port ifu_rsp_hsked, input, 1, a fetch bus response handshake occurred this cycle.
REQ-010 SHALL have port ifu_req_allow, output, 1, the fetch engine may issue a new bus request.
REQ-011 SHALL have port ifu_rsp_drop, output, 1, the current response is stale and SHALL be discarded.
REQ-012 SHALL have port redir_valid, output, 1, the redirect PC is pending for the fetch engine.
REQ-013 SHALL have port redir_ready, input, 1, the fetch engine accepts the redirect.
REQ-014 SHALL have port redir_pc, output, E203_PC_SIZE, the redirect target PC.

Function
REQ-015 SHALL drive pipe_flush_ack constantly 1, so flush_hsk = pipe_flush_req.
REQ-016 SHALL compute the target as pipe_flush_add_op1 + pipe_flush_add_op2, truncated to E203_PC_SIZE bits (wrap-around, no carry out), and register it into redir_pc on flush_hsk.
REQ-017 SHALL keep the outstanding count ost_cnt (2 bits): ost_nxt = ost_cnt + ifu_req_hsked - ifu_rsp_hsked, updated every cycle.
REQ-018 SHALL implement states IDLE, DRAIN and REDIR.
REQ-019 SHALL drive ifu_req_allow = (state==IDLE) & (ost_cnt < OSTD_MAX).
REQ-020 On flush_hsk in any state, SHALL load drop_cnt with ost_nxt and go to DRAIN if ost_nxt != 0, else to REDIR.
REQ-021 In DRAIN with no flush_hsk, SHALL decrement drop_cnt on each ifu_rsp_hsked and go to REDIR when drop_cnt goes from 1 to 0.
REQ-022 SHALL drive ifu_rsp_drop = (drop_cnt != 0).
REQ-023 SHALL drive redir_valid = (state==REDIR).
REQ-024 In REDIR, on redir_valid & redir_ready with no flush_hsk, SHALL go to IDLE next cycle.
REQ-025 On a simultaneous redirect handshake and flush_hsk, SHALL let the new flush win: redir_pc is overwritten and REQ-020 applies.
REQ-026 A flush arriving in DRAIN SHALL overwrite redir_pc and keep draining the remaining outstanding responses.
REQ-027 An ifu_req_hsked when ifu_req_allow=0, or an ifu_rsp_hsked when ost_cnt=0, is a protocol violation; the behaviour is then undefined and it SHALL be flagged by assertion.
REQ-028 The flush-to-redir_valid latency SHALL be 1 cycle when nothing is outstanding.

Reset
REQ-029 On rst_n low, asynchronously: state=IDLE, ost_cnt=0, drop_cnt=0, redir_pc=0, so redir_valid=0, ifu_rsp_drop=0, ifu_req_allow=1.
REQ-030 Reset mid-DRAIN or mid-REDIR SHALL abandon the pending redirect; responses after reset are not dropped.

Structure
REQ-031 SHALL take E203_PC_SIZE from the shared e203_defines.v; the state encodings SHALL be localparams of this module.
REQ-032 SHALL build all flops from sirv_gnrl_dfflr (the enable-load, async-reset flop) and use no other sub-module.

Verification
REQ-033 Idle flush: ost=0, op1=0x8000_0000, op2=4 -> redir_valid next cycle, redir_pc=0x8000_0004; redir_ready=1 -> IDLE.
REQ-034 Drain: two requests issued, then flush -> DRAIN with drop_cnt=2, ifu_req_allow=0; both responses have ifu_rsp_drop=1; REDIR the cycle after the second response.
REQ-035 Simultaneous events: in IDLE with ost=1, one cycle carries ifu_req_hsked, ifu_rsp_hsked and flush -> drop_cnt=1, DRAIN.
REQ-036 Override: in REDIR with redir_pc=0x100, flush op1=0x200, op2=0 in the same cycle as redir_ready -> stays REDIR, redir_pc=0x200.
REQ-037 Wrap: op1=0xFFFF_FFFE, op2=4 -> redir_pc=0x0000_0002.
REQ-038 Reset asserted in DRAIN -> all outputs at their reset values immediately; a response after reset has ifu_rsp_drop=0.

Source files
------------

// File: rtl/e203_ifu_flushrsp_pkg.sv
// Shared definitions for the IFU flush/response tracker.
// E203_PC_SIZE mirrors the core-wide PC width from e203_defines.v.
package e203_ifu_flushrsp_pkg;

    localparam int E203_PC_SIZE = 32;

    typedef logic [E203_PC_SIZE-1:0] pc_t;

    // Flush target wraps modulo 2^E203_PC_SIZE; the carry out is discarded.
    function automatic pc_t flush_target(input pc_t op1, input pc_t op2);
        return op1 + op2;
    endfunction

endpackage

// File: rtl/e203_ifu_flushrsp_dfflr.sv
// Generic enable-load flop with asynchronous active-low reset to zero.
module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst_n
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/e203_ifu_flushrsp.sv
// Tracks outstanding IFU fetches, drops stale responses after a pipeline
// flush and presents the flush target PC as a redirect to the fetch engine.
//
// state | meaning
// IDLE  | normal fetching, new requests allowed while below OSTD_MAX
// DRAIN | flush seen, discarding responses still in flight
// REDIR | redirect PC valid, waiting for the fetch engine to take it
module e203_ifu_flushrsp
    import e203_ifu_flushrsp_pkg::*;
#(
    parameter int OSTD_MAX = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pipe_flush_req,
    output logic                    pipe_flush_ack,
    input  logic [E203_PC_SIZE-1:0] pipe_flush_add_op1,
    input  logic [E203_PC_SIZE-1:0] pipe_flush_add_op2,
    input  logic                    ifu_req_hsked,
    input  logic                    ifu_rsp_hsked,
    output logic                    ifu_req_allow,
    output logic                    ifu_rsp_drop,
    output logic                    redir_valid,
    input  logic                    redir_ready,
    output logic [E203_PC_SIZE-1:0] redir_pc
);

    // IDLE must encode as zero: the flops reset to all-zeros.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_REDIR = 2'd2;

    localparam logic [1:0] OST_LIMIT = 2'(OSTD_MAX);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [1:0] ost_cnt;
    logic [1:0] ost_nxt;
    logic [1:0] drop_cnt;
    logic [1:0] drop_nxt;
    logic       flush_hsk;
    logic       redir_hsk;
    pc_t        flush_tgt;

    assign pipe_flush_ack = 1'b1;
    assign flush_hsk      = pipe_flush_req & pipe_flush_ack;
    assign redir_hsk      = redir_valid & redir_ready;
    assign flush_tgt      = flush_target(pipe_flush_add_op1, pipe_flush_add_op2);

    assign ost_nxt = ost_cnt + 2'(ifu_req_hsked) - 2'(ifu_rsp_hsked);

    // A new flush always wins, even against a same-cycle redirect handshake.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop_cnt;
        if (flush_hsk) begin
            drop_nxt  = ost_nxt;
            state_nxt = (ost_nxt != 2'd0) ? ST_DRAIN : ST_REDIR;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_DRAIN: begin
                    if (ifu_rsp_hsked && (drop_cnt != 2'd0)) begin
                        drop_nxt = drop_cnt - 2'd1;
                        if (drop_cnt == 2'd1) begin
                            state_nxt = ST_REDIR;
                        end
                    end
                end
                ST_REDIR: begin
                    if (redir_hsk) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    sirv_gnrl_dfflr #(.DW(2)) u_state_dff (
        .lden (1'b1),
        .dnxt (state_nxt),
        .qout (state),
        .clk  (clk),
        .rst_n(rst_n)
    );

    sirv_gnrl_dfflr #(.DW(2)) u_ost_dff (
        .lden (1'b1),
        .dnxt (ost_nxt),
        .qout (ost_cnt),
        .clk  (clk),
        .rst_n(rst_n)
    );

    sirv_gnrl_dfflr #(.DW(2)) u_drop_dff (
        .lden (1'b1),
        .dnxt (drop_nxt),
        .qout (drop_cnt),
        .clk  (clk),
        .rst_n(rst_n)
    );

    sirv_gnrl_dfflr #(.DW(E203_PC_SIZE)) u_pc_dff (
        .lden (flush_hsk),
        .dnxt (flush_tgt),
        .qout (redir_pc),
        .clk  (clk),
        .rst_n(rst_n)
    );

    assign ifu_req_allow = (state == ST_IDLE) && (ost_cnt < OST_LIMIT);
    assign ifu_rsp_drop  = (drop_cnt != 2'd0);
    assign redir_valid   = (state == ST_REDIR);

    a_req_when_blocked : assert property (@(posedge clk) disable iff (!rst_n)
        ifu_req_hsked |-> ifu_req_allow);

    a_rsp_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
        ifu_rsp_hsked |-> (ost_cnt != 2'd0));

endmodule

// File: tb/tb_e203_ifu_flushrsp.sv
// Randomized scoreboard bench for e203_ifu_flushrsp against a counting model.
module tb_e203_ifu_flushrsp;
    import e203_ifu_flushrsp_pkg::*;

    localparam int OSTD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pipe_flush_req = 1'b0;
    logic pipe_flush_ack;
    pc_t  pipe_flush_add_op1 = '0;
    pc_t  pipe_flush_add_op2 = '0;
    logic ifu_req_hsked = 1'b0;
    logic ifu_rsp_hsked = 1'b0;
    logic ifu_req_allow;
    logic ifu_rsp_drop;
    logic redir_valid;
    logic redir_ready = 1'b0;
    pc_t  redir_pc;

    e203_ifu_flushrsp #(.OSTD_MAX(OSTD)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pipe_flush_req    (pipe_flush_req),
        .pipe_flush_ack    (pipe_flush_ack),
        .pipe_flush_add_op1(pipe_flush_add_op1),
        .pipe_flush_add_op2(pipe_flush_add_op2),
        .ifu_req_hsked     (ifu_req_hsked),
        .ifu_rsp_hsked     (ifu_rsp_hsked),
        .ifu_req_allow     (ifu_req_allow),
        .ifu_rsp_drop      (ifu_rsp_drop),
        .redir_valid       (redir_valid),
        .redir_ready       (redir_ready),
        .redir_pc          (redir_pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input pc_t act, input pc_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetches in flight, responses still to be discarded,
    // and whether a redirect is owed to the fetch engine.
    int  m_ost  = 0;
    int  m_drop = 0;
    bit  m_want = 0;
    pc_t m_pc   = '0;

    function automatic bit exp_allow();
        return !m_want && (m_ost < OSTD);
    endfunction

    function automatic bit exp_valid();
        return m_want && (m_drop == 0);
    endfunction

    typedef struct {
        bit  allow;
        bit  drop;
        bit  valid;
        pc_t pc;
    } status_t;

    status_t status_q[$];
    bit      rsp_q[$];
    pc_t     redir_q[$];

    // One clock cycle of stimulus: drive at negedge, record expectations, advance model.
    task automatic step(input bit req, input bit rsp, input bit fl,
                        input pc_t a, input pc_t b, input bit rdy);
        int nost;
        @(negedge clk);
        ifu_req_hsked      = req;
        ifu_rsp_hsked      = rsp;
        pipe_flush_req     = fl;
        pipe_flush_add_op1 = a;
        pipe_flush_add_op2 = b;
        redir_ready        = rdy;
        #1;
        status_q.push_back('{exp_allow(), m_drop != 0, exp_valid(), m_pc});
        if (rsp) rsp_q.push_back(m_drop != 0);
        if (exp_valid() && rdy) redir_q.push_back(m_pc);
        nost = m_ost + int'(req) - int'(rsp);
        if (fl) begin
            m_want = 1'b1;
            m_pc   = a + b;
            m_drop = nost;
        end else if (m_drop > 0) begin
            if (rsp) m_drop--;
        end else if (m_want && rdy) begin
            m_want = 1'b0;
        end
        m_ost = nost;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        ifu_req_hsked  = 1'b0;
        ifu_rsp_hsked  = 1'b0;
        pipe_flush_req = 1'b0;
        redir_ready    = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_allow", pc_t'(ifu_req_allow), 1);
        chk("rst_drop", pc_t'(ifu_rsp_drop), 0);
        chk("rst_valid", pc_t'(redir_valid), 0);
        chk("rst_pc", redir_pc, 0);
        m_ost  = 0;
        m_drop = 0;
        m_want = 1'b0;
        m_pc   = '0;
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compares once per cycle and whenever a response or redirect handshake is visible.
    initial begin
        status_t s;
        forever begin
            @(negedge clk);
            #2;
            if (status_q.size() > 0) begin
                s = status_q.pop_front();
                chk("allow", pc_t'(ifu_req_allow), pc_t'(s.allow));
                chk("rsp_drop_level", pc_t'(ifu_rsp_drop), pc_t'(s.drop));
                chk("redir_valid", pc_t'(redir_valid), pc_t'(s.valid));
                chk("redir_pc_level", redir_pc, s.pc);
                chk("flush_ack", pc_t'(pipe_flush_ack), 1);
            end
            if (ifu_rsp_hsked) begin
                if (rsp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: response with no expectation at %0t", $time);
                end else begin
                    chk("rsp_drop", pc_t'(ifu_rsp_drop), pc_t'(rsp_q.pop_front()));
                end
            end
            if (redir_valid && redir_ready) begin
                if (redir_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL redir_unexpected: redirect pc 0x%08h not expected at %0t", redir_pc, $time);
                end else begin
                    chk("redir_hsk_pc", redir_pc, redir_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3;
        chk("init_allow", pc_t'(ifu_req_allow), 1);
        chk("init_valid", pc_t'(redir_valid), 0);
        chk("init_drop", pc_t'(ifu_rsp_drop), 0);
        chk("init_pc", redir_pc, 0);
        #4;
        rst_n = 1'b1;

        // Idle flush: redirect visible one cycle later.
        step(0, 0, 1, 32'h8000_0000, 32'h4, 0);
        step(0, 0, 0, '0, '0, 1);
        chk("idle_flush_valid", pc_t'(redir_valid), 1);
        chk("idle_flush_pc", redir_pc, 32'h8000_0004);
        idle();
        chk("idle_flush_back", pc_t'(ifu_req_allow), 1);

        // Drain two outstanding fetches.
        step(1, 0, 0, '0, '0, 0);
        step(1, 0, 0, '0, '0, 0);
        step(0, 0, 1, 32'h1000, 32'h20, 0);
        idle();
        chk("drain_allow", pc_t'(ifu_req_allow), 0);
        chk("drain_drop", pc_t'(ifu_rsp_drop), 1);
        step(0, 1, 0, '0, '0, 0);
        step(0, 1, 0, '0, '0, 0);
        chk("drain_second_drop", pc_t'(ifu_rsp_drop), 1);
        chk("drain_not_yet_valid", pc_t'(redir_valid), 0);
        step(0, 0, 0, '0, '0, 1);
        chk("drain_then_redir", pc_t'(redir_valid), 1);
        chk("drain_pc", redir_pc, 32'h1020);
        idle();

        // Request, response and flush together with one outstanding.
        step(1, 0, 0, '0, '0, 0);
        step(1, 1, 1, 32'h300, 32'h4, 0);
        idle();
        chk("simul_drop", pc_t'(ifu_rsp_drop), 1);
        chk("simul_valid", pc_t'(redir_valid), 0);
        step(0, 1, 0, '0, '0, 0);
        step(0, 0, 0, '0, '0, 1);
        chk("simul_redir", pc_t'(redir_valid), 1);
        idle();

        // New flush wins over a same-cycle redirect accept.
        step(0, 0, 1, 32'h100, 32'h0, 0);
        step(0, 0, 1, 32'h200, 32'h0, 1);
        idle();
        chk("override_valid", pc_t'(redir_valid), 1);
        chk("override_pc", redir_pc, 32'h200);
        step(0, 0, 0, '0, '0, 1);

        // Target wraps around the PC width.
        step(0, 0, 1, 32'hFFFF_FFFE, 32'h4, 0);
        step(0, 0, 0, '0, '0, 1);
        chk("wrap_pc", redir_pc, 32'h0000_0002);
        idle();

        // Reset while draining abandons the redirect.
        step(1, 0, 0, '0, '0, 0);
        step(1, 0, 0, '0, '0, 0);
        step(0, 0, 1, 32'h4000, 32'h0, 0);
        idle();
        chk("pre_reset_drop", pc_t'(ifu_rsp_drop), 1);
        do_reset();
        step(1, 0, 0, '0, '0, 0);
        step(0, 1, 0, '0, '0, 0);
        chk("post_reset_drop", pc_t'(ifu_rsp_drop), 0);
        idle();

        for (int i = 0; i < 3000; i++) begin
            bit  rq;
            bit  rs;
            bit  fl;
            bit  rd;
            pc_t a;
            pc_t b;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                rq = exp_allow() && ($urandom_range(0, 1) == 1);
                rs = (m_ost > 0) && ($urandom_range(0, 2) == 0);
                fl = ($urandom_range(0, 9) == 0);
                rd = ($urandom_range(0, 1) == 1);
                a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | pc_t'($urandom_range(0, 15))) : pc_t'($urandom);
                b  = ($urandom_range(0, 1) == 1) ? pc_t'($urandom_range(0, 64)) : pc_t'($urandom);
                step(rq, rs, fl, a, b, rd);
            end
        end

        idle();
        idle();
        @(negedge clk);
        #3;
        chk("rsp_q_empty", pc_t'(rsp_q.size()), 0);
        chk("redir_q_empty", pc_t'(redir_q.size()), 0);
        chk("status_q_empty", pc_t'(status_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
